// File: rtl/direct_cache_ctrl.sv
// direct_cache_ctrl
//   Sequencing controller for a direct-mapped byte cache. Holds the tag/valid
//   arrays, decides hit/miss per CPU byte read, refills missing lines from main
//   memory beat by beat into an external data array, supports whole-cache
//   invalidate (flush) and keeps saturating hit/miss counters.
//
// Ports
//   clk_i, rst_ni            clock / asynchronous active-low reset
//   cpu_req_i, cpu_addr_i    CPU read request (held until ack) and byte address
//   cpu_ack_o, cpu_hit_o     one-cycle ack; hit flag valid with ack
//   flush_i                  invalidate-all request (pulse or level)
//   busy_o                   high whenever the controller is not idle
//   mem_req_o, mem_addr_o    line refill request and line-aligned address
//   mem_valid_i, mem_data_i  in-order refill beats, beat 0 first
//   arr_we_o ... arr_wdata_o data-array write port (one beat per cycle)
//   arr_rindex_o, arr_roffset_o  data-array read address (latched CPU address)
//   hit_cnt_o, miss_cnt_o    saturating event counters
module direct_cache_ctrl #(
    parameter int unsigned  TAG_W      = 16,
    parameter int unsigned  INDEX_W    = 8,
    parameter int unsigned  OFFSET_W   = 8,
    parameter int unsigned  BEAT_W     = 32,
    localparam int unsigned ADDR_W     = TAG_W + INDEX_W + OFFSET_W,
    localparam int unsigned BEATS      = ((2 ** OFFSET_W) * 8) / BEAT_W,
    localparam int unsigned BEAT_IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cpu_req_i,
    input  logic [ADDR_W-1:0]     cpu_addr_i,
    output logic                  cpu_ack_o,
    output logic                  cpu_hit_o,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  mem_req_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    input  logic                  mem_valid_i,
    input  logic [BEAT_W-1:0]     mem_data_i,
    output logic                  arr_we_o,
    output logic [INDEX_W-1:0]    arr_windex_o,
    output logic [BEAT_IDX_W-1:0] arr_wbeat_o,
    output logic [BEAT_W-1:0]     arr_wdata_o,
    output logic [INDEX_W-1:0]    arr_rindex_o,
    output logic [OFFSET_W-1:0]   arr_roffset_o,
    output logic [15:0]           hit_cnt_o,
    output logic [15:0]           miss_cnt_o
);

    localparam int unsigned LINES = 2 ** INDEX_W;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StRefill,
        StRespond,
        StFlush
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 hit_q, hit_d;
    logic [BEAT_IDX_W-1:0] beat_q, beat_d;
    logic [INDEX_W-1:0]   fidx_q, fidx_d;
    logic                 fpend_q, fpend_d;
    logic                 mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [15:0]          hit_cnt_q, hit_cnt_d;
    logic [15:0]          miss_cnt_q, miss_cnt_d;
    logic [LINES-1:0]     valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q [LINES];
    logic                 tag_we;

    logic [TAG_W-1:0]     addr_tag;
    logic [INDEX_W-1:0]   addr_idx;
    logic [OFFSET_W-1:0]  addr_off;
    logic                 lookup_hit;

    assign addr_tag   = addr_q[ADDR_W-1 -: TAG_W];
    assign addr_idx   = addr_q[OFFSET_W +: INDEX_W];
    assign addr_off   = addr_q[OFFSET_W-1:0];
    // Valid gates the tag compare, so tags never need clearing.
    assign lookup_hit = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        hit_d      = hit_q;
        beat_d     = beat_q;
        fidx_d     = fidx_q;
        fpend_d    = fpend_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        valid_d    = valid_q;
        tag_we     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Pending or fresh flush beats a simultaneous CPU request.
                if (flush_i || fpend_q) begin
                    state_d = StFlush;
                    fpend_d = 1'b0;
                    fidx_d  = '0;
                end else if (cpu_req_i) begin
                    addr_d  = cpu_addr_i;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (lookup_hit) begin
                    hit_d   = 1'b1;
                    state_d = StRespond;
                    if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
                end else begin
                    hit_d      = 1'b0;
                    state_d    = StRefill;
                    beat_d     = '0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {addr_tag, addr_idx, {OFFSET_W{1'b0}}};
                    if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
                end
            end
            StRefill: begin
                if (mem_valid_i) begin
                    beat_d = beat_q + 1'b1;
                    // Line becomes valid only once the last beat is written.
                    if (beat_q == BEAT_IDX_W'(BEATS - 1)) begin
                        valid_d[addr_idx] = 1'b1;
                        tag_we            = 1'b1;
                        mem_req_d         = 1'b0;
                        state_d           = StRespond;
                    end
                end
            end
            StRespond: begin
                state_d = StIdle;
            end
            StFlush: begin
                valid_d[fidx_q] = 1'b0;
                fidx_d          = fidx_q + 1'b1;
                if (fidx_q == INDEX_W'(LINES - 1)) state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Flush arriving mid-transaction is remembered and run at the next idle.
        if (flush_i && (state_q != StIdle) && (state_q != StFlush)) fpend_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            hit_q      <= 1'b0;
            beat_q     <= '0;
            fidx_q     <= '0;
            fpend_q    <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            hit_q      <= hit_d;
            beat_q     <= beat_d;
            fidx_q     <= fidx_d;
            fpend_q    <= fpend_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            valid_q    <= valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (tag_we) tag_q[addr_idx] <= addr_tag;
    end

    assign cpu_ack_o     = (state_q == StRespond);
    assign cpu_hit_o     = (state_q == StRespond) && hit_q;
    assign busy_o        = (state_q != StIdle);
    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = mem_addr_q;
    assign arr_we_o      = (state_q == StRefill) && mem_valid_i;
    assign arr_windex_o  = addr_idx;
    assign arr_wbeat_o   = beat_q;
    assign arr_wdata_o   = mem_data_i;
    assign arr_rindex_o  = addr_idx;
    assign arr_roffset_o = addr_off;
    assign hit_cnt_o     = hit_cnt_q;
    assign miss_cnt_o    = miss_cnt_q;

endmodule

// File: tb/tb_direct_cache_ctrl.sv
// Directed bench for direct_cache_ctrl with a scoreboard of expected CPU
// responses and a beat-driving main-memory model.
module tb_direct_cache_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        cpu_ack;
    logic        cpu_hit;
    logic        flush;
    logic        busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic        arr_we;
    logic [7:0]  arr_windex;
    logic [5:0]  arr_wbeat;
    logic [31:0] arr_wdata;
    logic [7:0]  arr_rindex;
    logic [7:0]  arr_roffset;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    direct_cache_ctrl dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .cpu_req_i     (cpu_req),
        .cpu_addr_i    (cpu_addr),
        .cpu_ack_o     (cpu_ack),
        .cpu_hit_o     (cpu_hit),
        .flush_i       (flush),
        .busy_o        (busy),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_valid_i   (mem_valid),
        .mem_data_i    (mem_data),
        .arr_we_o      (arr_we),
        .arr_windex_o  (arr_windex),
        .arr_wbeat_o   (arr_wbeat),
        .arr_wdata_o   (arr_wdata),
        .arr_rindex_o  (arr_rindex),
        .arr_roffset_o (arr_roffset),
        .hit_cnt_o     (hit_cnt),
        .miss_cnt_o    (miss_cnt)
    );

    typedef struct {
        bit          hit;
        logic [31:0] addr;
        int          samp;  // clock edge at which the request is sampled
        int          lat;   // edges from sample edge to ack capture
        int          mreq;  // cycles mem_req must be high
    } sb_entry_t;

    sb_entry_t sb[$];
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int wr_cnt   = 0;
    int mreq_cyc = 0;
    int sent     = 0;
    int n_hit    = 0;
    int n_miss   = 0;
    bit stall_mode = 0;
    bit phase      = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Main memory: drives one beat per cycle (or every other cycle when stalling).
    initial begin
        mem_valid = 0;
        mem_data  = 0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_valid) sent++;
            if (mem_req && rst_n) begin
                if (stall_mode) begin
                    mem_valid = phase;
                    phase     = !phase;
                end else begin
                    mem_valid = 1;
                end
                mem_data = 32'hD000_0000 | sent;
            end else begin
                mem_valid = 0;
                sent      = 0;
                phase     = 0;
            end
        end
    end

    // Monitor: array writes and CPU acks, checked against the scoreboard.
    initial forever begin
        sb_entry_t e;
        logic [31:0] exp_data;
        @(negedge clk);
        if (!rst_n) begin
            sb.delete();
            wr_cnt   = 0;
            mreq_cyc = 0;
        end else begin
            if (mem_req) mreq_cyc++;
            if (arr_we) begin
                exp_data = 32'hD000_0000 | wr_cnt;
                check("wr_beat", arr_wbeat, wr_cnt[5:0]);
                check("wr_data", arr_wdata, exp_data);
                if (sb.size() == 0) check("wr_no_txn", arr_we, 1'b0);
                else check("wr_index", arr_windex, sb[0].addr[15:8]);
                wr_cnt++;
            end
            if (cpu_ack) begin
                if (sb.size() == 0) begin
                    check("ack_unexpected", cpu_ack, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("ack_hit", cpu_hit, e.hit);
                    check("ack_rindex", arr_rindex, e.addr[15:8]);
                    check("ack_roffset", arr_roffset, e.addr[7:0]);
                    check("ack_latency", cyc + 1 - e.samp, e.lat);
                    check("ack_writes", wr_cnt, e.hit ? 0 : 64);
                    check("ack_memreq_cycles", mreq_cyc, e.mreq);
                    if (!e.hit) check("ack_mem_addr", mem_addr, {e.addr[31:8], 8'h00});
                end
                wr_cnt   = 0;
                mreq_cyc = 0;
            end
        end
    end

    // Called at a negedge; delay is edges until the request is sampled.
    task automatic send(input logic [31:0] a, input bit hit, input int delay);
        sb_entry_t e;
        e.hit  = hit;
        e.addr = a;
        e.samp = cyc + delay;
        e.lat  = hit ? 2 : (stall_mode ? 130 : 66);
        e.mreq = hit ? 0 : (stall_mode ? 128 : 64);
        sb.push_back(e);
        cpu_req  = 1;
        cpu_addr = a;
        if (hit) n_hit++;
        else n_miss++;
    endtask

    task automatic wait_ack();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_ack && n < 2000);
        check("ack_timeout", cpu_ack, 1'b1);
        cpu_req = 0;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_hit_cnt"}, hit_cnt, n_hit);
        check({tag, "_miss_cnt"}, miss_cnt, n_miss);
    endtask

    task automatic check_reset_outputs();
        check("rst_ack", cpu_ack, 1'b0);
        check("rst_hit", cpu_hit, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_arr_we", arr_we, 1'b0);
        check("rst_windex", arr_windex, 8'h0);
        check("rst_rindex", arr_rindex, 8'h0);
        check("rst_roffset", arr_roffset, 8'h0);
        check("rst_hit_cnt", hit_cnt, 16'h0);
        check("rst_miss_cnt", miss_cnt, 16'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst_n    = 0;
        cpu_req  = 0;
        cpu_addr = 0;
        flush    = 0;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Cold miss
        send(32'h0001FE01, 0, 1);
        wait_ack();
        check_counts("t1");

        // Hits, the second back-to-back with the first ack
        @(negedge clk);
        send(32'h0001FE01, 1, 1);
        wait_ack();
        send(32'h0001FEFF, 1, 2);
        wait_ack();
        check_counts("t2");

        // Conflict: same index, different tag evicts the line
        @(negedge clk);
        send(32'h0002FE00, 0, 1);
        wait_ack();
        @(negedge clk);
        send(32'h0001FE01, 0, 1);
        wait_ack();
        check_counts("t3");

        // Memory stalls every other cycle
        @(negedge clk);
        stall_mode = 1;
        send(32'h12345678, 0, 1);
        wait_ack();
        stall_mode = 0;
        @(negedge clk);
        send(32'h123456AA, 1, 1);
        wait_ack();
        check_counts("t4");

        // Flush and request together: flush runs first, line 0xFE lost
        @(negedge clk);
        flush = 1;
        send(32'h0001FE01, 0, 258);
        @(negedge clk);
        flush = 0;
        check("flush_busy_start", busy, 1'b1);
        repeat (255) @(negedge clk);
        check("flush_busy_last", busy, 1'b1);
        @(negedge clk);
        check("flush_done_idle", busy, 1'b0);
        wait_ack();
        check_counts("t5a");

        // Flush during refill is deferred until after the ack
        @(negedge clk);
        send(32'h0003AB10, 0, 1);
        repeat (20) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        wait_ack();
        send(32'h0003AB10, 0, 259);
        wait_ack();
        check_counts("t5b");

        // Reset in the middle of a refill
        @(negedge clk);
        send(32'h0004CD00, 0, 1);
        n = 0;
        while (sent < 30 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("t6_beat30_reached", mem_req, 1'b1);
        rst_n   = 0;
        cpu_req = 0;
        #1;
        check_reset_outputs();
        n_hit  = 0;
        n_miss = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        send(32'h0004CD00, 0, 1);
        wait_ack();
        @(negedge clk);
        send(32'h0004CD42, 1, 1);
        wait_ack();
        check_counts("t6");
        check("sb_drained", sb.size(), 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
